poca_hsm_initiator: RTL

HSM-side initiator for the POCA authentication protocol. It latches a challenge (seed, cycle count, elliptic-curve base point), drives it into the chip-side POCA primitive, and captures the `{public key, hash}` response. It checks the hash against an enrolled value, then delivers the HSM public key to close the key exchange. It sits between the HSM host controller and the chip's POCA port, one session at a time.

---
 rtl/poca_hsm_initiator.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/poca_hsm_initiator.sv
// HSM-side POCA initiator: issues a challenge, checks the chip's response hash, delivers the HSM key.
// Define POCA_HSM_TIMEOUT_EN to add a per-wait-state timeout (fail codes 2'b10 / 2'b11).
module poca_hsm_initiator #(
    parameter int unsigned MULT_SIZE  = 283,
    parameter int unsigned HASH_SIZE  = 256,
    parameter int unsigned SEED_SIZE  = 128,
    parameter int unsigned CYCLE_SIZE = 32,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [SEED_SIZE-1:0]           chal_seed,
    input  logic [CYCLE_SIZE-1:0]          chal_cycle,
    input  logic [MULT_SIZE-1:0]           base_g,
    input  logic [MULT_SIZE-1:0]           hsm_key,
    input  logic [HASH_SIZE-1:0]           expected_hash,
    output logic [SEED_SIZE-1:0]           seed,
    output logic [CYCLE_SIZE-1:0]          cycle,
    output logic [MULT_SIZE-1:0]           dh_G,
    output logic                           go,
    input  logic [MULT_SIZE+HASH_SIZE-1:0] response,
    input  logic                           response_ready,
    output logic [MULT_SIZE-1:0]           public_key_hsm,
    output logic                           public_key_hsm_received,
    input  logic                           secret_key_ready,
    output logic [MULT_SIZE-1:0]           chip_key,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [1:0]                     fail_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RESP, S_CHECK, S_WAIT_KEY, S_DONE
    } state_e;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("poca_hsm_initiator: TIMEOUT must be >= 1");
    end

    state_e                  state_q, state_d;
    logic [SEED_SIZE-1:0]    lat_seed_q, lat_seed_d;
    logic [CYCLE_SIZE-1:0]   lat_cycle_q, lat_cycle_d;
    logic [MULT_SIZE-1:0]    lat_g_q, lat_g_d;
    logic [MULT_SIZE-1:0]    lat_hkey_q, lat_hkey_d;
    logic [HASH_SIZE-1:0]    lat_hash_q, lat_hash_d;
    logic [SEED_SIZE-1:0]    seed_q, seed_d;
    logic [CYCLE_SIZE-1:0]   cycle_q, cycle_d;
    logic [MULT_SIZE-1:0]    dh_g_q, dh_g_d;
    logic                    go_q, go_d;
    logic [MULT_SIZE-1:0]    pkh_q, pkh_d;
    logic                    pkh_rcv_q, pkh_rcv_d;
    logic [MULT_SIZE-1:0]    chip_key_q, chip_key_d;
    logic [HASH_SIZE-1:0]    resp_hash_q, resp_hash_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [1:0]              fail_q, fail_d;
    logic                    rr_q, skr_q, skr_rise_q;
    logic                    rr_rise_c;
    logic                    tmo_c;

    // Only fresh rising edges count, so levels left over from a previous session are ignored.
    assign rr_rise_c = response_ready & ~rr_q;

`ifdef POCA_HSM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Cleared while entering a wait state, counts every cycle spent waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE || state_q == S_CHECK) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT_RESP || state_q == S_WAIT_KEY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign tmo_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lat_seed_q  <= '0;
            lat_cycle_q <= '0;
            lat_g_q     <= '0;
            lat_hkey_q  <= '0;
            lat_hash_q  <= '0;
            seed_q      <= '0;
            cycle_q     <= '0;
            dh_g_q      <= '0;
            go_q        <= 1'b0;
            pkh_q       <= '0;
            pkh_rcv_q   <= 1'b0;
            chip_key_q  <= '0;
            resp_hash_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 2'b00;
            rr_q        <= 1'b0;
            skr_q       <= 1'b0;
            skr_rise_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_seed_q  <= lat_seed_d;
            lat_cycle_q <= lat_cycle_d;
            lat_g_q     <= lat_g_d;
            lat_hkey_q  <= lat_hkey_d;
            lat_hash_q  <= lat_hash_d;
            seed_q      <= seed_d;
            cycle_q     <= cycle_d;
            dh_g_q      <= dh_g_d;
            go_q        <= go_d;
            pkh_q       <= pkh_d;
            pkh_rcv_q   <= pkh_rcv_d;
            chip_key_q  <= chip_key_d;
            resp_hash_q <= resp_hash_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            rr_q        <= response_ready;
            skr_q       <= secret_key_ready;
            skr_rise_q  <= secret_key_ready & ~skr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_seed_d  = lat_seed_q;
        lat_cycle_d = lat_cycle_q;
        lat_g_d     = lat_g_q;
        lat_hkey_d  = lat_hkey_q;
        lat_hash_d  = lat_hash_q;
        seed_d      = seed_q;
        cycle_d     = cycle_q;
        dh_g_d      = dh_g_q;
        go_d        = go_q;
        pkh_d       = pkh_q;
        pkh_rcv_d   = pkh_rcv_q;
        chip_key_d  = chip_key_q;
        resp_hash_d = resp_hash_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lat_seed_d  = chal_seed;
                    lat_cycle_d = chal_cycle;
                    lat_g_d     = base_g;
                    lat_hkey_d  = hsm_key;
                    lat_hash_d  = expected_hash;
                    pass_d      = 1'b0;
                    fail_d      = 2'b00;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                seed_d  = lat_seed_q;
                cycle_d = lat_cycle_q;
                dh_g_d  = lat_g_q;
                go_d    = 1'b1;
                state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (rr_rise_c) begin
                    chip_key_d  = response[MULT_SIZE+HASH_SIZE-1:HASH_SIZE];
                    resp_hash_d = response[HASH_SIZE-1:0];
                    state_d     = S_CHECK;
                end else if (tmo_c) begin
                    fail_d  = 2'b10;
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                if (resp_hash_q == lat_hash_q) begin
                    pkh_d     = lat_hkey_q;
                    pkh_rcv_d = 1'b1;
                    state_d   = S_WAIT_KEY;
                end else begin
                    fail_d  = 2'b01;
                    state_d = S_DONE;
                end
            end
            S_WAIT_KEY: begin
                if (skr_rise_q) begin
                    pass_d  = 1'b1;
                    fail_d  = 2'b00;
                    state_d = S_DONE;
                end else if (tmo_c) begin
                    fail_d  = 2'b11;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Handshake levels drop together with the done pulse.
        if (state_d == S_DONE) begin
            go_d      = 1'b0;
            pkh_rcv_d = 1'b0;
            done_d    = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign seed                    = seed_q;
    assign cycle                   = cycle_q;
    assign dh_G                    = dh_g_q;
    assign go                      = go_q;
    assign public_key_hsm          = pkh_q;
    assign public_key_hsm_received = pkh_rcv_q;
    assign chip_key                = chip_key_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign pass                    = pass_q;
    assign fail_code               = fail_q;

endmodule
